decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
Parameters:
REQ-001 The block SHALL expose parameter PC_W, default 32, width of the carried program counter.
REQ-002 The block SHALL expose parameter DEPTH, default 2, output buffer entries; legal range 1..4.
REQ-003 The block SHALL expose parameter CNT_W, default 16, width of each statistics counter.
Ports:
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  discard all buffered and in-flight entries.
REQ-007 in_valid / in_ready  in / out  1 / 1  input handshake.
REQ-008 in_inst / in_pc  in  32 / PC_W  instruction word and its address.
REQ-009 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-010 out_pc, out_imm, out_opcode, out_funct3, out_funct7  out  PC_W, 32, 7, 3, 7  decoded fields.
REQ-011 out_rs1, out_rs2, out_rd  out  5 each  register indices.
REQ-012 out_fmt  out  6  one-hot {R,I,S,B,U,J}, bit 5 = R; out_invalid  out  1  illegal encoding.
REQ-013 decoded_count, invalid_count  out  CNT_W each  statistics.

Function
REQ-014 Transfer SHALL occur on an edge where valid and ready are both high; in_ready = (occupancy < DEPTH) and not flush; no pass-through when full.
REQ-015 An instruction accepted at edge N SHALL appear at out_valid after edge N, i.e. one-cycle latency; output order SHALL equal input order.
REQ-016 Simultaneous push and pop SHALL be supported when not full; occupancy unchanged; pointers wrap modulo DEPTH.
REQ-017 Classification (RV32I): LUI 0110111 U; AUIPC 0010111 U; JAL 1101111 J; JALR 1100111 I, funct3=000; BRANCH 1100011 B, funct3 not 010/011; LOAD 0000011 I, funct3 in {000,001,010,100,101}; STORE 0100011 S, funct3 <= 010; OP-IMM 0010011 I; MISC-MEM 0001111 I; SYSTEM 1110011 I; OP 0110011 R.
REQ-018 OP-IMM shifts: funct3=001 requires funct7=0000000; funct3=101 requires funct7 in {0000000,0100000}; otherwise invalid.
REQ-019 OP: funct7=0000000 legal for all funct3; 0100000 legal only with funct3 000/101; anything else invalid (see REQ-027).
REQ-020 Any other opcode, or in_inst[1:0] != 11, SHALL be invalid.
REQ-021 Immediates SHALL be standard RV32I sign-extended to 32 bits per format; R-format imm = 0.
REQ-022 Unused register fields SHALL read 0: rs1 for U/J; rs2 for I/U/J; rd for S/B.
REQ-023 Invalid entries SHALL still be emitted with out_invalid=1, out_fmt=0, out_imm=0, rs1/rs2/rd=0; opcode/funct3/funct7/pc raw.
REQ-024 decoded_count SHALL increment per accepted instruction; invalid_count per accepted invalid one; both saturate at all-ones and are unaffected by flush.
REQ-025 flush high SHALL empty the buffer at that edge, force in_ready=0 that cycle, and deassert out_valid from the next cycle.

Reset
REQ-026 While rst_n is low: occupancy 0, pointers 0, out_valid 0, all out_* data 0, counters 0, in_ready 0; in_ready rises in the first cycle after rst_n deasserts. Reset mid-transfer SHALL drop all entries.

Configuration
REQ-027 Macro DECODE_STAGE_M_EN: defined -> OP with funct7=0000001 (any funct3) is legal R-format (MUL/DIV); undefined -> such encodings are invalid.

Verification
REQ-028 in_inst=0x800010B7 -> next cycle out_fmt=000010 (U), out_imm=0x80001000, out_rd=1, out_invalid=0.
REQ-029 in_inst=0xFFF08113 -> out_fmt=010000 (I), out_imm=0xFFFFFFFF, rs1=1, rd=2, rs2=0.
REQ-030 in_inst=0x00000000 -> out_invalid=1, out_fmt=0, invalid_count=1, decoded_count=1.
REQ-031 in_inst=0x022081B3 -> with DECODE_STAGE_M_EN out_fmt=100000, rs1=1, rs2=2, rd=3; without it out_invalid=1.
REQ-032 DEPTH=2, out_ready=0, push 3 back-to-back -> in_ready=0 after second accept; release out_ready -> both emerge in order, third then accepted.
REQ-033 Buffer holding 2 entries, pulse flush with in_valid=1 -> out_valid=0 next cycle, flush-cycle input not emitted, counters unchanged.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I decoder with a small skid FIFO on the output.
// Optional macro DECODE_STAGE_M_EN accepts OP funct7=0000001 (MUL/DIV).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               drop all buffered entries
//   in_valid/in_ready   input handshake (in_inst, in_pc)
//   out_valid/out_ready output handshake (decoded fields)
//   out_pc/imm/opcode/funct3/funct7/rs1/rs2/rd/fmt/invalid
//   decoded_count, invalid_count  saturating statistics
module decode_stage #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [31:0]      out_imm,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [5:0]       out_fmt,
  output logic             out_invalid,
  output logic [CNT_W-1:0] decoded_count,
  output logic [CNT_W-1:0] invalid_count
);

  localparam int PTR_W =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST =
    PTR_W'(DEPTH - 1);
  localparam logic [2:0] FULL = 3'(DEPTH);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_MISC  = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  localparam logic [6:0] F7_Z   = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;
  localparam logic [6:0] F7_M   = 7'b0000001;

  // fmt bit positions, R is the MSB
  localparam int F_R = 5;
  localparam int F_I = 4;
  localparam int F_S = 3;
  localparam int F_B = 2;
  localparam int F_U = 1;
  localparam int F_J = 0;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     imm;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [5:0]      fmt;
    logic            invalid;
  } entry_t;

`ifdef DECODE_STAGE_M_EN
  localparam logic M_OK = 1'b1;
`else
  localparam logic M_OK = 1'b0;
`endif

  // ---------------- decode ----------------
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] fmt_raw;
  logic       legal;
  logic [5:0] fmt;
  logic [31:0] imm;
  entry_t     dec;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  // Opcodes all end in 2'b11, so a bad low
  // pair never matches and falls to default.
  always_comb begin
    fmt_raw = '0;
    legal   = 1'b0;
    unique case (1'b1)
      (opc == OP_LUI),
      (opc == OP_AUIPC): begin
        fmt_raw[F_U] = 1'b1;
        legal = 1'b1;
      end
      (opc == OP_JAL): begin
        fmt_raw[F_J] = 1'b1;
        legal = 1'b1;
      end
      (opc == OP_JALR): begin
        fmt_raw[F_I] = 1'b1;
        legal = (f3 == 3'b000);
      end
      (opc == OP_BR): begin
        fmt_raw[F_B] = 1'b1;
        legal = (f3 != 3'b010) &&
                (f3 != 3'b011);
      end
      (opc == OP_LOAD): begin
        fmt_raw[F_I] = 1'b1;
        legal = (f3 != 3'b011) &&
                (f3 != 3'b110) &&
                (f3 != 3'b111);
      end
      (opc == OP_STORE): begin
        fmt_raw[F_S] = 1'b1;
        legal = (f3 <= 3'b010);
      end
      (opc == OP_IMM): begin
        fmt_raw[F_I] = 1'b1;
        unique case (f3)
          3'b001:  legal = (f7 == F7_Z);
          3'b101:  legal = (f7 == F7_Z) ||
                           (f7 == F7_ALT);
          default: legal = 1'b1;
        endcase
      end
      (opc == OP_MISC),
      (opc == OP_SYS): begin
        fmt_raw[F_I] = 1'b1;
        legal = 1'b1;
      end
      (opc == OP_OP): begin
        fmt_raw[F_R] = 1'b1;
        legal = (f7 == F7_Z) ||
                ((f7 == F7_ALT) &&
                 ((f3 == 3'b000) ||
                  (f3 == 3'b101))) ||
                (M_OK && (f7 == F7_M));
      end
      default: begin
        fmt_raw = '0;
        legal   = 1'b0;
      end
    endcase
  end

  assign fmt = legal ? fmt_raw : 6'b0;

  always_comb begin
    imm = '0;
    unique case (1'b1)
      fmt[F_I]:
        imm = {{20{in_inst[31]}},
               in_inst[31:20]};
      fmt[F_S]:
        imm = {{20{in_inst[31]}},
               in_inst[31:25],
               in_inst[11:7]};
      fmt[F_B]:
        imm = {{19{in_inst[31]}},
               in_inst[31], in_inst[7],
               in_inst[30:25],
               in_inst[11:8], 1'b0};
      fmt[F_U]:
        imm = {in_inst[31:12], 12'b0};
      fmt[F_J]:
        imm = {{11{in_inst[31]}},
               in_inst[31],
               in_inst[19:12],
               in_inst[20],
               in_inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // fmt is zero when illegal, so the register
  // fields clear along with it.
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.imm     = imm;
    dec.opcode  = opc;
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.fmt     = fmt;
    dec.invalid = ~legal;
    if (fmt[F_R] | fmt[F_I] |
        fmt[F_S] | fmt[F_B])
      dec.rs1 = in_inst[19:15];
    if (fmt[F_R] | fmt[F_S] | fmt[F_B])
      dec.rs2 = in_inst[24:20];
    if (fmt[F_R] | fmt[F_I] |
        fmt[F_U] | fmt[F_J])
      dec.rd = in_inst[11:7];
  end

  // ---------------- buffer ----------------
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic             alive_q, alive_d;
  logic             push, pop;
  entry_t           head;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // alive_q holds in_ready low until the
  // first edge after reset release.
  assign alive_d  = 1'b1;
  assign in_ready = alive_q &&
                    (cnt_q < FULL) && !flush;
  assign out_valid = (cnt_q != 3'd0);
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    dcnt_d = dcnt_q;
    icnt_d = icnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = dec;
        wr_d = nxt(wr_q);
      end
      if (pop)
        rd_d = nxt(rd_q);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 3'd1;
        2'b01:   cnt_d = cnt_q - 3'd1;
        default: cnt_d = cnt_q;
      endcase
    end
    if (push && (dcnt_q != '1))
      dcnt_d = dcnt_q + 1'b1;
    if (push && dec.invalid &&
        (icnt_q != '1))
      icnt_d = icnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      icnt_q  <= '0;
      alive_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      icnt_q  <= icnt_d;
      alive_q <= alive_d;
    end
  end

  assign head = out_valid ? mem_q[rd_q] : '0;

  assign out_pc        = head.pc;
  assign out_imm       = head.imm;
  assign out_opcode    = head.opcode;
  assign out_funct3    = head.funct3;
  assign out_funct7    = head.funct7;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_rd        = head.rd;
  assign out_fmt       = head.fmt;
  assign out_invalid   = head.invalid;
  assign decoded_count = dcnt_q;
  assign invalid_count = icnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage.
// Expected entries queued on accept, monitor pops.
module tb_decode_stage;

  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_inst;
  logic [31:0]   in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_imm;
  logic [6:0]    out_opcode;
  logic [2:0]    out_funct3;
  logic [6:0]    out_funct7;
  logic [4:0]    out_rs1;
  logic [4:0]    out_rs2;
  logic [4:0]    out_rd;
  logic [5:0]    out_fmt;
  logic          out_invalid;
  logic [CW-1:0] decoded_count;
  logic [CW-1:0] invalid_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  fmt;
    logic        inv;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  decode_stage #(
    .PC_W(32), .DEPTH(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm),
    .out_opcode(out_opcode),
    .out_funct3(out_funct3),
    .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_fmt(out_fmt),
    .out_invalid(out_invalid),
    .decoded_count(decoded_count),
    .invalid_count(invalid_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [31:0] pc,
    input logic [31:0] imm,
    input logic [6:0]  opc,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [4:0]  rd,
    input logic [5:0]  fmt,
    input logic        inv
  );
    exp_t e;
    e = '{pc, imm, opc, f3, f7,
          rs1, rs2, rd, fmt, inv};
    return e;
  endfunction

  task automatic chk(
    input string name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h",
               name, act, exp);
    end
  endtask

  // Monitor samples 2 units after the negedge
  // drive point, well clear of the posedge.
  always @(negedge clk) begin
    exp_t a;
    exp_t e;
    #2;
    if (rst_n && out_valid && out_ready &&
        !flush) begin
      a = '{out_pc, out_imm, out_opcode,
            out_funct3, out_funct7, out_rs1,
            out_rs2, out_rd, out_fmt,
            out_invalid};
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected act=%h exp=none",
                 a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL out_entry act=%h exp=%h",
                   a, e);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge
  // after the accepting edge.
  task automatic send(
    input logic [31:0] inst,
    input logic [31:0] pc,
    input exp_t e
  );
    int n = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 0);
  endtask

  localparam logic [5:0] R = 6'b100000;
  localparam logic [5:0] I = 6'b010000;
  localparam logic [5:0] S = 6'b001000;
  localparam logic [5:0] B = 6'b000100;
  localparam logic [5:0] U = 6'b000010;
  localparam logic [5:0] J = 6'b000001;

`ifdef DECODE_STAGE_M_EN
  localparam int INV13 = 5;
`else
  localparam int INV13 = 6;
`endif

  initial begin
    int dc;
    int ic;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_inst = '0;
    in_pc = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_imm", 64'(out_imm), 0);
    chk("rst_dcnt", 64'(decoded_count), 0);
    chk("rst_icnt", 64'(invalid_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_up", 64'(in_ready), 1);

    send(32'h00000000, 32'h1000,
      mk(32'h1000, 0, 7'h00, 0, 0,
         0, 0, 0, 0, 1));
    chk("latency_valid", 64'(out_valid), 1);
    chk("zero_dcnt", 64'(decoded_count), 1);
    chk("zero_icnt", 64'(invalid_count), 1);
    send(32'h800010B7, 32'h1004,
      mk(32'h1004, 32'h80001000, 7'h37, 1,
         7'h40, 0, 0, 1, U, 0));
    send(32'hFFF08113, 32'h1008,
      mk(32'h1008, 32'hFFFFFFFF, 7'h13, 0,
         7'h7F, 1, 0, 2, I, 0));
`ifdef DECODE_STAGE_M_EN
    send(32'h022081B3, 32'h100C,
      mk(32'h100C, 0, 7'h33, 0, 7'h01,
         1, 2, 3, R, 0));
`else
    send(32'h022081B3, 32'h100C,
      mk(32'h100C, 0, 7'h33, 0, 7'h01,
         0, 0, 0, 0, 1));
`endif
    send(32'h0020A423, 32'h1010,
      mk(32'h1010, 32'h8, 7'h23, 2, 0,
         1, 2, 0, S, 0));
    send(32'hFE208EE3, 32'h1014,
      mk(32'h1014, 32'hFFFFFFFC, 7'h63, 0,
         7'h7F, 1, 2, 0, B, 0));
    send(32'h008000EF, 32'h1018,
      mk(32'h1018, 32'h8, 7'h6F, 0, 0,
         0, 0, 1, J, 0));
    send(32'h00002063, 32'h101C,
      mk(32'h101C, 0, 7'h63, 2, 0,
         0, 0, 0, 0, 1));
    send(32'h4010D093, 32'h1020,
      mk(32'h1020, 32'h401, 7'h13, 5,
         7'h20, 1, 0, 1, I, 0));
    send(32'h40109093, 32'h1024,
      mk(32'h1024, 0, 7'h13, 1, 7'h20,
         0, 0, 0, 0, 1));
    send(32'h402081B3, 32'h1028,
      mk(32'h1028, 0, 7'h33, 0, 7'h20,
         1, 2, 3, R, 0));
    send(32'h402091B3, 32'h102C,
      mk(32'h102C, 0, 7'h33, 1, 7'h20,
         0, 0, 0, 0, 1));
    send(32'h800010B4, 32'h1030,
      mk(32'h1030, 0, 7'h34, 1, 7'h40,
         0, 0, 0, 0, 1));
    drain();
    chk("dcnt_13", 64'(decoded_count), 13);
    chk("icnt_13", 64'(invalid_count),
        64'(INV13));

    // backpressure: two fill, third stalls
    out_ready = 1'b0;
    send(32'h800010B7, 32'h2000,
      mk(32'h2000, 32'h80001000, 7'h37, 1,
         7'h40, 0, 0, 1, U, 0));
    send(32'hFFF08113, 32'h2004,
      mk(32'h2004, 32'hFFFFFFFF, 7'h13, 0,
         7'h7F, 1, 0, 2, I, 0));
    chk("full_in_ready", 64'(in_ready), 0);
    fork
      send(32'h0020A423, 32'h2008,
        mk(32'h2008, 32'h8, 7'h23, 2, 0,
           1, 2, 0, S, 0));
      begin
        repeat (3) @(negedge clk);
        chk("stall_in_ready", 64'(in_ready), 0);
        chk("stall_out_valid",
            64'(out_valid), 1);
        chk("stall_dcnt",
            64'(decoded_count), 15);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("dcnt_16", 64'(decoded_count), 16);

    // flush with two buffered entries
    out_ready = 1'b0;
    send(32'h402081B3, 32'h3000,
      mk(32'h3000, 0, 7'h33, 0, 7'h20,
         1, 2, 3, R, 0));
    send(32'h4010D093, 32'h3004,
      mk(32'h3004, 32'h401, 7'h13, 5,
         7'h20, 1, 0, 1, I, 0));
    dc = int'(decoded_count);
    ic = int'(invalid_count);
    flush = 1'b1;
    in_valid = 1'b1;
    in_inst = 32'h00000000;
    in_pc = 32'h3008;
    q.delete();
    #1;
    chk("flush_in_ready", 64'(in_ready), 0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 64'(out_valid), 0);
    chk("flush_dcnt", 64'(decoded_count),
        64'(dc));
    chk("flush_icnt", 64'(invalid_count),
        64'(ic));
    chk("dcnt_18", 64'(dc), 18);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_flush_valid", 64'(out_valid), 0);

    // saturate both counters
    for (int k = 0; k < 30; k++)
      send(32'h00000000, 32'h4000 + 32'(4*k),
        mk(32'h4000 + 32'(4*k), 0, 0, 0, 0,
           0, 0, 0, 0, 1));
    drain();
    chk("dcnt_sat", 64'(decoded_count), 31);
    chk("icnt_sat", 64'(invalid_count), 31);

    // reset with an entry in flight
    out_ready = 1'b0;
    send(32'h800010B7, 32'h5000,
      mk(32'h5000, 32'h80001000, 7'h37, 1,
         7'h40, 0, 0, 1, U, 0));
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_pc", 64'(out_pc), 0);
    chk("mid_rst_dcnt", 64'(decoded_count), 0);
    chk("mid_rst_ready", 64'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 0);
    chk("post_rst_ready", 64'(in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
